// File: rtl/alm_pkg.sv
// Shared definitions for the ALM operand log encoder.
// Holds the log-width helper, the default operand widths, the default
// mantissa widths and per-operand encoded-result structs at default width.
package alm_pkg;

  // Width of a leading-one index for an operand of v bits.
  function automatic int alm_log2(input int v);
    return $clog2(v);
  endfunction

  localparam int ALM_DEF_A_BW = 32;
  localparam int ALM_DEF_B_BW = 32;

  localparam int ALM_DEF_A_LOG_W  = alm_log2(ALM_DEF_A_BW);
  localparam int ALM_DEF_B_LOG_W  = alm_log2(ALM_DEF_B_BW);
  localparam int ALM_DEF_A_MANT_W = ALM_DEF_A_BW - 1;
  localparam int ALM_DEF_B_MANT_W = ALM_DEF_B_BW - 1;

  // Encoded operand: characteristic, MSB-aligned mantissa, zero flag.
  typedef struct packed {
    logic [ALM_DEF_A_LOG_W-1:0]  k;
    logic [ALM_DEF_A_MANT_W-1:0] log_format;
    logic                        zero;
  } alm_log_a_t;

  typedef struct packed {
    logic [ALM_DEF_B_LOG_W-1:0]  k;
    logic [ALM_DEF_B_MANT_W-1:0] log_format;
    logic                        zero;
  } alm_log_b_t;

endpackage

// File: rtl/alm_log_encode_lane.sv
// Combinational log encoder for one operand, split in two independent halves
// so the top can place a pipeline register between them.
//   op_i      : operand entering stage 1
//   k_o       : leading-one index of op_i (0 when op_i is 0)
//   zero_o    : op_i == 0
//   sh_op_i   : raw operand held in stage 1
//   sh_k_i    : leading-one index held in stage 1
//   sh_zero_i : zero flag held in stage 1
//   fmt_o     : MSB-aligned mantissa, truncated to the top M bits
module alm_log_encode_lane
  import alm_pkg::*;
#(
  parameter int BW = 32,
  parameter int M  = BW - 1
) (
  input  logic [BW-1:0]         op_i,
  output logic [$clog2(BW)-1:0] k_o,
  output logic                  zero_o,
  input  logic [BW-1:0]         sh_op_i,
  input  logic [$clog2(BW)-1:0] sh_k_i,
  input  logic                  sh_zero_i,
  output logic [BW-2:0]         fmt_o
);

  localparam int KW = alm_log2(BW);
  localparam logic [KW-1:0] MAX_K = KW'(BW - 1);

  logic [KW-1:0] shamt;
  logic [BW-2:0] shifted;
  logic          shift_unused_msb;
  logic [BW-2:0] keep_mask;

  // Priority encoder: the last set bit scanned upward wins.
  always_comb begin
    k_o = '0;
    for (int i = 0; i < BW; i++) begin
      if (op_i[i]) k_o = KW'(i);
    end
  end

  assign zero_o = ~|op_i;

  // Shifting by BW-1-K moves the leading one into the MSB, which is dropped:
  // it is implied by the characteristic.
  assign shamt = MAX_K - sh_k_i;
  assign {shift_unused_msb, shifted} = sh_op_i << shamt;

  // Keep only the top M mantissa bits; all ones when M = BW-1.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < BW - 1; i++) begin
      keep_mask[i] = (i >= BW - 1 - M);
    end
  end

  assign fmt_o = sh_zero_i ? '0 : (shifted & keep_mask);

endmodule

// File: rtl/alm_operand_log_encoder.sv
// Two-stage valid/ready pipeline converting operands A and B into ALM log
// format (leading-one position + MSB-aligned mantissa + zero flag).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand pair handshake, a/b operands
//   out_valid/out_ready : encoded pair handshake
//   log_*/log_format_*/zero_* : encoded operands, travelling in lockstep
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A stage advances when it is empty or its successor advances
// (adv2 = !out_valid || out_ready, adv1 = !s1_valid || adv2), and
// in_ready = adv1, combinational from out_ready with no skid buffer.
// Outputs hold while out_valid && !out_ready. Empty stages keep their data.
module alm_operand_log_encoder
  import alm_pkg::*;
#(
  parameter int A_BW = ALM_DEF_A_BW,
  parameter int B_BW = ALM_DEF_B_BW,
  parameter int M_A  = A_BW - 1,
  parameter int M_B  = B_BW - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_BW-1:0]         a,
  input  logic [B_BW-1:0]         b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(A_BW)-1:0] log_a,
  output logic [A_BW-2:0]         log_format_a,
  output logic                    zero_a,
  output logic [$clog2(B_BW)-1:0] log_b,
  output logic [B_BW-2:0]         log_format_b,
  output logic                    zero_b
);

  localparam int KA = alm_log2(A_BW);
  localparam int KB = alm_log2(B_BW);

  typedef struct packed {
    logic [KA-1:0]   k;
    logic [A_BW-2:0] log_format;
    logic            zero;
  } enc_a_t;

  typedef struct packed {
    logic [KB-1:0]   k;
    logic [B_BW-2:0] log_format;
    logic            zero;
  } enc_b_t;

  // Stage 1: raw operand plus leading-one result.
  logic            s1_valid_q;
  logic [A_BW-1:0] s1_a_q;
  logic [KA-1:0]   s1_ka_q, s1_ka_d;
  logic            s1_za_q, s1_za_d;
  logic [B_BW-1:0] s1_b_q;
  logic [KB-1:0]   s1_kb_q, s1_kb_d;
  logic            s1_zb_q, s1_zb_d;

  // Stage 2: registered outputs.
  logic            out_valid_q;
  enc_a_t          out_a_q, out_a_d;
  enc_b_t          out_b_q, out_b_d;

  logic            adv1, adv2;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  alm_log_encode_lane #(.BW(A_BW), .M(M_A)) u_lane_a (
    .op_i      (a),
    .k_o       (s1_ka_d),
    .zero_o    (s1_za_d),
    .sh_op_i   (s1_a_q),
    .sh_k_i    (s1_ka_q),
    .sh_zero_i (s1_za_q),
    .fmt_o     (out_a_d.log_format)
  );

  alm_log_encode_lane #(.BW(B_BW), .M(M_B)) u_lane_b (
    .op_i      (b),
    .k_o       (s1_kb_d),
    .zero_o    (s1_zb_d),
    .sh_op_i   (s1_b_q),
    .sh_k_i    (s1_kb_q),
    .sh_zero_i (s1_zb_q),
    .fmt_o     (out_b_d.log_format)
  );

  assign out_a_d.k    = s1_ka_q;
  assign out_a_d.zero = s1_za_q;
  assign out_b_d.k    = s1_kb_q;
  assign out_b_d.zero = s1_zb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_ka_q     <= '0;
      s1_za_q     <= 1'b0;
      s1_b_q      <= '0;
      s1_kb_q     <= '0;
      s1_zb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q  <= a;
          s1_ka_q <= s1_ka_d;
          s1_za_q <= s1_za_d;
          s1_b_q  <= b;
          s1_kb_q <= s1_kb_d;
          s1_zb_q <= s1_zb_d;
        end
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_a_q <= out_a_d;
          out_b_q <= out_b_d;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign log_a        = out_a_q.k;
  assign log_format_a = out_a_q.log_format;
  assign zero_a       = out_a_q.zero;
  assign log_b        = out_b_q.k;
  assign log_format_b = out_b_q.log_format;
  assign zero_b       = out_b_q.zero;

endmodule

// File: tb/tb_alm_operand_log_encoder.sv
module tb_alm_operand_log_encoder;

  localparam int BW = 8;
  localparam int MA = 3;
  localparam int MB = 7;
  localparam int W  = 22;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] log_a, log_b;
  logic [6:0] log_format_a, log_format_b;
  logic       zero_a, zero_b;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int stall_n = 0;

  alm_operand_log_encoder #(.A_BW(BW), .B_BW(BW), .M_A(MA), .M_B(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .log_a        (log_a),
    .log_format_a (log_format_a),
    .zero_a       (zero_a),
    .log_b        (log_b),
    .log_format_b (log_format_b),
    .zero_b       (zero_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference encoding from the arithmetic definition: {K, mantissa, zero}.
  function automatic logic [10:0] enc(input int x, input int m);
    int k, mant, fmt;
    if (x == 0) return {3'd0, 7'd0, 1'b1};
    k = 0;
    while (k < BW - 1 && (1 << (k + 1)) <= x) k++;
    mant = x - (1 << k);
    fmt  = mant * (1 << (BW - 1 - k));
    fmt  = (fmt / (1 << (BW - 1 - m))) * (1 << (BW - 1 - m));
    return {3'(k), 7'(fmt), 1'b0};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  // Samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      exp_q.delete();
      stall_n = 0;
    end else begin
      if (exp_q.size() > 0 && !out_valid) begin
        stall_n++;
        chk("output_latency", 32'(stall_n <= 1), 32'd1);
      end else begin
        stall_n = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_pair",
              32'({log_a, log_format_a, zero_a, log_b, log_format_b, zero_b}),
              32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back({enc(a, MA), enc(b, MB)});
    end
  end

  // ---------------- driver tasks ----------------
  // Sends one pair into an empty pipeline and checks the literal result.
  task automatic lit_pair(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [10:0] ea, input logic [10:0] eb);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_lat1"}, 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat2"}, 32'(out_valid), 32'd1);
    chk({name, "_a"}, 32'({log_a, log_format_a, zero_a}), 32'(ea));
    chk({name, "_b"}, 32'({log_b, log_format_b, zero_b}), 32'(eb));
    @(negedge clk);
  endtask

  task automatic rand_ops();
    logic [7:0] v [2];
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i] = 8'd0;
        1:       v[i] = 8'(1 << $urandom_range(0, 7));
        2:       v[i] = 8'hFF;
        default: v[i] = 8'($urandom_range(0, 255));
      endcase
    end
    a = v[0];
    b = v[1];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs",
        32'({log_a, log_format_a, zero_a, log_b, log_format_b, zero_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the reference model
    chk("model_13",  32'(enc(13, 7)),  32'({3'd3, 7'b1010000, 1'b0}));
    chk("model_0",   32'(enc(0, 7)),   32'({3'd0, 7'b0000000, 1'b1}));
    chk("model_255", 32'(enc(255, 3)), 32'({3'd7, 7'b1110000, 1'b0}));
    chk("model_4b",  32'(enc(75, 3)),  32'({3'd6, 7'b0010000, 1'b0}));

    // Directed literal pairs
    lit_pair("p13_1",   8'd13,  8'd1,   {3'd3, 7'b1010000, 1'b0}, {3'd0, 7'b0000000, 1'b0});
    lit_pair("p0_255",  8'd0,   8'd255, {3'd0, 7'b0000000, 1'b1}, {3'd7, 7'b1111111, 1'b0});
    lit_pair("p255_80", 8'd255, 8'h80,  {3'd7, 7'b1110000, 1'b0}, {3'd7, 7'b0000000, 1'b0});
    lit_pair("p4b_4b",  8'h4B,  8'h4B,  {3'd6, 7'b0010000, 1'b0}, {3'd6, 7'b0010110, 1'b0});

    // Six back-to-back pairs: six consecutive out_valid cycles
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("stream_out_valid", 32'(out_valid), 32'(c >= 2 && c <= 7));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      in_valid = (c < 6);
      rand_ops();
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Backpressure: three pairs offered while out_ready is low
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      a = 8'(10 + idx); b = 8'(200 - idx);
      #1;
      if (c >= 2) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (c == 3) chk("stall_out_valid", 32'(out_valid), 32'd1);
      if (in_ready) idx++;
      @(negedge clk);
    end
    chk("stall_accepted", 32'(idx), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 3);
      a = 8'(10 + idx); b = 8'(200 - idx);
      #1;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    in_valid = 1'b1; rand_ops();
    @(negedge clk);
    rand_ops();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_ghost", 32'(out_valid), 32'd0);
    lit_pair("post_rst", 8'd6, 8'd0, {3'd2, 7'b1000000, 1'b0}, {3'd0, 7'b0000000, 1'b1});

    // Randomized traffic with random backpressure and rare resets
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      rand_ops();
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
